cordic_div_core: RTL and testbench
==================================

// Module: cordic_div_core
// PURPOSE
//  Fixed-point divider c = a/b using linear-mode (vectoring) CORDIC; inverse of the CORDIC multiplier core.
//  Iterative, one iteration per clock; start/rdy handshake identical to the multiplier core, so it drops into
//  the same test wrappers and datapaths.
// PARAMETERS
//  N     16  operand/result width, signed two's complement
//  FRAC   8  fractional bits (Q(N-1-FRAC).FRAC); legal 0..N-2
// PORTS
//  clk    in   1  clock, rising edge
//  rst    in   1  reset, synchronous, active-high
//  a      in   N  dividend, sampled on the accepting edge only
//  b      in   N  divisor, sampled on the accepting edge only
//  start  in   1  request; accepted on an edge where state==IDLE
//  c      out  N  quotient, registered, held until next rdy
//  rdy    out  1  one-cycle pulse: c valid
//  busy   out  1  high while state!=IDLE
//  ovf    out  1  (CORDIC_DIV_FLAGS_EN only) result saturated, valid with rdy, held
//  dz     out  1  (CORDIC_DIV_FLAGS_EN only) b==0, valid with rdy, held
// BEHAVIOUR
//  Reset: state=IDLE; c=0, rdy=0, busy=0, ovf=0, dz=0. rst mid-operation aborts; no rdy for that op.
//  States: IDLE -(start)-> RUN -(cnt==0)-> FIN -> IDLE.
//  Accept edge (IDLE & start): y<=sext(a)<<FRAC (2N+2 bits), x<=sext(b), z<=0 (N+2 bits),
//   cnt<=N-1, bz<=(b==0), sa<=a[N-1]. Start while busy ignored (no queueing).
//  RUN, one edge per s=cnt (N-1 down to 0):
//   y==0          : y,z unchanged (freeze; exact quotients come out exact)
//   sign(y)==sign(x): y<=y-(x<<s), z<=z+(1<<s)
//   else          : y<=y+(x<<s), z<=z-(1<<s)
//   cnt==0 -> FIN, else cnt<=cnt-1.
//  FIN edge: c<=result, rdy<=1, state<=IDLE. Every other edge: rdy<=0.
//   bz          : c = sa ? 0x80..0 : 0x7F..F; dz=1, ovf=1
//   z>2^(N-1)-1 : c=0x7F..F, ovf=1;  z<-2^(N-1): c=0x80..0, ovf=1
//   else        : c=z[N-1:0], ovf=0, dz=0
//  Latency: rdy high in the cycle after the (N+1)th edge following the accept edge; constant, incl. b==0.
//  rdy cycle is IDLE: start there is accepted (back-to-back period N+2 cycles).
//  Accuracy: exact when a/b representable; otherwise |c - a/b| < 1 LSB (either neighbour legal).
//  No combinational path input->output; a,b may change freely after the accept edge.
// CONFIGURATION
//  CORDIC_DIV_FLAGS_EN defined: ports ovf,dz present, behave as above.
//  Undefined: ports ovf,dz absent; saturation and latency unchanged.
// TESTING (N=16, FRAC=8)
//  a=0x0100,b=0x0080 start 1 cycle -> rdy 1 cycle at edge 17 after accept, c=0x0200, ovf=0,dz=0
//  a=0xFF00,b=0x0080 -> c=0xFE00; a=0x0100,b=0xFF80 -> c=0xFE00; a=0xFF00,b=0xFF80 -> c=0x0200
//  a=0x0100,b=0x0300 -> c in {0x0055,0x0056}; sweep 2000 random pairs vs real-math model, +/-1 LSB
//  a=0x7F00,b=0x0040 -> c=0x7FFF, ovf=1; a=0x8000,b=0x0040 -> c=0x8000, ovf=1
//  a=0xFF00,b=0x0000 -> c=0x8000, dz=1; a=0x0000,b=0x0000 -> c=0x7FFF, dz=1; latency still 17
//  start held high -> rdy every 18 cycles, start while busy ignored; rst 5 cycles after accept -> no rdy, c=0,busy=0

Source files
------------

// File: rtl/cordic_div_if.sv
// Request/response bundle for the linear-mode CORDIC divider.
// Optional flag signals ovf/dz exist only when CORDIC_DIV_FLAGS_EN is defined.
interface cordic_div_if #(
  parameter int N = 16
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         start;
  logic [N-1:0] c;
  logic         rdy;
  logic         busy;
`ifdef CORDIC_DIV_FLAGS_EN
  logic         ovf;
  logic         dz;

  modport master (
    output a, b, start,
    input  c, rdy, busy, ovf, dz
  );
  modport slave (
    input  a, b, start,
    output c, rdy, busy, ovf, dz
  );
`else
  modport master (
    output a, b, start,
    input  c, rdy, busy
  );
  modport slave (
    input  a, b, start,
    output c, rdy, busy
  );
`endif
endinterface

// File: rtl/cordic_div_core.sv
// Iterative fixed-point divider c = a/b, linear vectoring CORDIC, one step/clk.
// Define CORDIC_DIV_FLAGS_EN to expose the ovf/dz status flags.
module cordic_div_core #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  cordic_div_if.slave io
);

  localparam int YW = 2*N + 2;
  localparam int ZW = N + 2;
  localparam int CW = $clog2(N);

  localparam logic signed [ZW-1:0] ZMAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [ZW-1:0] ZMIN = {3'b111, {(N-1){1'b0}}};
  localparam logic [N-1:0] CMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] CMIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic signed [YW-1:0] y_q, y_d;
  logic signed [YW-1:0] x_q, x_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 bz_q, bz_d;
  logic                 sa_q, sa_d;
  logic                 rdy_q, rdy_d;
  logic [N-1:0]         c_q, c_d;
  logic [N-1:0]         res_c;
  logic signed [YW-1:0] x_sh;
  logic signed [ZW-1:0] z_unit;
`ifdef CORDIC_DIV_FLAGS_EN
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;
  logic                 res_ovf;
`endif

  assign x_sh   = x_q <<< cnt_q;
  assign z_unit = {{(ZW-1){1'b0}}, 1'b1} << cnt_q;

  // Saturate on divide-by-zero (sign follows dividend) or z out of range
  always_comb begin
    res_c = z_q[N-1:0];
`ifdef CORDIC_DIV_FLAGS_EN
    res_ovf = 1'b0;
`endif
    if (bz_q) begin
      res_c = sa_q ? CMIN : CMAX;
`ifdef CORDIC_DIV_FLAGS_EN
      res_ovf = 1'b1;
`endif
    end else if (z_q > ZMAX) begin
      res_c = CMAX;
`ifdef CORDIC_DIV_FLAGS_EN
      res_ovf = 1'b1;
`endif
    end else if (z_q < ZMIN) begin
      res_c = CMIN;
`ifdef CORDIC_DIV_FLAGS_EN
      res_ovf = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    x_d     = x_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    bz_d    = bz_q;
    sa_d    = sa_q;
    c_d     = c_q;
    rdy_d   = 1'b0;
`ifdef CORDIC_DIV_FLAGS_EN
    ovf_d   = ovf_q;
    dz_d    = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = RUN;
          y_d     = {{(YW-N){io.a[N-1]}}, io.a} << FRAC;
          x_d     = {{(YW-N){io.b[N-1]}}, io.b};
          z_d     = '0;
          cnt_d   = CW'(N-1);
          bz_d    = (io.b == '0);
          sa_d    = io.a[N-1];
        end
      end
      RUN: begin
        // A zero remainder freezes y/z so exact quotients stay exact
        if (y_q != '0) begin
          if (y_q[YW-1] == x_q[YW-1]) begin
            y_d = y_q - x_sh;
            z_d = z_q + z_unit;
          end else begin
            y_d = y_q + x_sh;
            z_d = z_q - z_unit;
          end
        end
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        c_d     = res_c;
`ifdef CORDIC_DIV_FLAGS_EN
        ovf_d   = res_ovf;
        dz_d    = bz_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      x_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      bz_q    <= 1'b0;
      sa_q    <= 1'b0;
      c_q     <= '0;
      rdy_q   <= 1'b0;
`ifdef CORDIC_DIV_FLAGS_EN
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      x_q     <= x_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      bz_q    <= bz_d;
      sa_q    <= sa_d;
      c_q     <= c_d;
      rdy_q   <= rdy_d;
`ifdef CORDIC_DIV_FLAGS_EN
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign io.c    = c_q;
  assign io.rdy  = rdy_q;
  assign io.busy = (state_q != IDLE);
`ifdef CORDIC_DIV_FLAGS_EN
  assign io.ovf  = ovf_q;
  assign io.dz   = dz_q;
`endif

endmodule

// File: tb/tb_cordic_div_core.sv
// Directed and randomized-tolerance bench for cordic_div_core (N=16, FRAC=8).
// Flag checks are compiled in when CORDIC_DIV_FLAGS_EN is defined.
module tb_cordic_div_core;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pq[$];

  logic [15:0] oc;
  int          ol;
  logic        s_ovf;
  logic        s_dz;
  logic [15:0] ra;
  logic [15:0] rb;
  int          ia;
  int          ib;
  int          ic;
  real         rq;
  real         re;

  cordic_div_if #(.N(16)) bus ();

  cordic_div_core #(.N(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: accept, then count edges until rdy (bounded)
  task automatic do_op(input logic [15:0] ia_, input logic [15:0] ib_,
                       output logic [15:0] c_, output int lat);
    @(negedge clk);
    bus.a     = ia_;
    bus.b     = ib_;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) begin
        lat = k;
        break;
      end
    end
    c_ = bus.c;
    s_ovf = 1'b0;
    s_dz  = 1'b0;
`ifdef CORDIC_DIV_FLAGS_EN
    s_ovf = bus.ovf;
    s_dz  = bus.dz;
`endif
    if (lat < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic dir(input string tag, input logic [15:0] ia_,
                     input logic [15:0] ib_, input logic [15:0] ec,
                     input logic eo, input logic ed);
    logic [15:0] c_;
    int          l_;
    do_op(ia_, ib_, c_, l_);
    chk({tag, "_c"}, c_, ec);
    chk({tag, "_lat"}, l_, 17);
`ifdef CORDIC_DIV_FLAGS_EN
    chk({tag, "_ovf"}, s_ovf, eo);
    chk({tag, "_dz"}, s_dz, ed);
`else
    if (eo || ed) ;
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst       = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c", bus.c, 16'h0000);
    chk("rst_rdy", bus.rdy, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
`ifdef CORDIC_DIV_FLAGS_EN
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_dz", bus.dz, 1'b0);
`endif
    rst = 1'b0;

    dir("pp", 16'h0100, 16'h0080, 16'h0200, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pulse_rdy", bus.rdy, 1'b0);
    chk("hold_c", bus.c, 16'h0200);
    dir("np", 16'hFF00, 16'h0080, 16'hFE00, 1'b0, 1'b0);
    dir("pn", 16'h0100, 16'hFF80, 16'hFE00, 1'b0, 1'b0);
    dir("nn", 16'hFF00, 16'hFF80, 16'h0200, 1'b0, 1'b0);
    dir("frac", 16'h0180, 16'h0200, 16'h00C0, 1'b0, 1'b0);
    dir("zero", 16'h0000, 16'h0123, 16'h0000, 1'b0, 1'b0);

    do_op(16'h0100, 16'h0300, oc, ol);
    chk("third_c", (oc == 16'h0055) || (oc == 16'h0056), 1'b1);
    chk("third_lat", ol, 17);

    dir("satp", 16'h7F00, 16'h0040, 16'h7FFF, 1'b1, 1'b0);
    dir("satn", 16'h8000, 16'h0040, 16'h8000, 1'b1, 1'b0);
    dir("dzn", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1);
    dir("dz0", 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    dir("clr", 16'h0100, 16'h0080, 16'h0200, 1'b0, 1'b0);

    // start held high: accepts on each rdy cycle, period 18
    @(negedge clk);
    bus.a     = 16'h0100;
    bus.b     = 16'h0080;
    bus.start = 1'b1;
    @(posedge clk);
    pq.delete();
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) begin
        pq.push_back(k);
        chk("b2b_c", bus.c, 16'h0200);
      end
    end
    bus.start = 1'b0;
    chk("b2b_n", pq.size(), 3);
    if (pq.size() == 3) begin
      chk("b2b_p0", pq[0], 17);
      chk("b2b_p1", pq[1] - pq[0], 18);
      chk("b2b_p2", pq[2] - pq[1], 18);
    end
    repeat (25) @(posedge clk);
    #1;
    chk("b2b_idle", bus.busy, 1'b0);

    // start pulse while busy must be ignored
    @(negedge clk);
    bus.a     = 16'h0100;
    bus.b     = 16'h0080;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pq.delete();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) chk("busy_mid", bus.busy, 1'b1);
      if (k == 5) begin
        bus.a     = 16'h0300;
        bus.b     = 16'h0001;
        bus.start = 1'b1;
      end
      if (k == 6) bus.start = 1'b0;
      if (bus.rdy) begin
        pq.push_back(k);
        chk("ign_c", bus.c, 16'h0200);
      end
    end
    chk("ign_n", pq.size(), 1);
    if (pq.size() == 1) chk("ign_lat", pq[0], 17);

    // reset mid-operation aborts without rdy
    dir("pre", 16'hFF00, 16'hFF80, 16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    bus.a     = 16'h0100;
    bus.b     = 16'h0080;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pq.delete();
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst = 1'b0;
        chk("ar_c", bus.c, 16'h0000);
        chk("ar_busy", bus.busy, 1'b0);
        chk("ar_rdy", bus.rdy, 1'b0);
      end
      if (bus.rdy) pq.push_back(k);
    end
    chk("ar_nordy", pq.size(), 0);
    dir("post", 16'hFF00, 16'h0080, 16'hFE00, 1'b0, 1'b0);

    // Random pairs against a real-valued model, +/-1 LSB after clamping
    for (int i = 0; i < 2000; i++) begin
      if (i % 2 == 1) ra = 16'($urandom);
      else ra = 16'(int'($urandom_range(0, 4095)) - 2048);
      rb = 16'($urandom);
      if (rb == 16'h0000) rb = 16'h0001;
      do_op(ra, rb, oc, ol);
      ia = int'($signed(ra));
      ib = int'($signed(rb));
      ic = int'($signed(oc));
      rq = ($itor(ia) * 256.0) / $itor(ib);
      if (rq > 32767.0) rq = 32767.0;
      if (rq < -32768.0) rq = -32768.0;
      re = $itor(ic) - rq;
      chk($sformatf("rnd%0d_%h_%h", i, ra, rb),
          (re > -1.0) && (re < 1.0), 1'b1);
      chk("rnd_lat", ol, 17);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
